// File: rtl/array_arb2.sv
// array_arb2: two-client round-robin arbiter in front of one shared array memory.
// One memory access is outstanding at a time: IDLE -> REQ -> RESP -> IDLE.
// Optional macro ARRAY_ARB_LOCK_EN adds c0_lock/c1_lock and a LOCKED state.
// A locked client keeps the array across several accesses, for example a
// read-modify-write.
//
// Handshake semantics (client and memory side):
//   Client: c*_valid and c*_addr/we/di stay stable from assertion until the
//   cycle in which c*_ready is 1. c*_ready is a single-cycle pulse, and c*_do
//   is valid in that cycle. c*_do holds until the next response to that client.
//   Memory: m_valid and m_addr/we/di stay stable until a rising edge samples
//   m_ready=1, and m_do is captured at that edge. m_ready is ignored while
//   m_valid is 0.
module array_arb2 #(
  parameter int W_DATA = 8,
  parameter int W_ADDR = 8
) (
  input  logic              clk,
  input  logic              nrst,
`ifdef ARRAY_ARB_LOCK_EN
  input  logic              c0_lock,
  input  logic              c1_lock,
`endif
  input  logic [W_ADDR-1:0] c0_addr,
  input  logic              c0_we,
  input  logic [W_DATA-1:0] c0_di,
  input  logic              c0_valid,
  output logic [W_DATA-1:0] c0_do,
  output logic              c0_ready,
  input  logic [W_ADDR-1:0] c1_addr,
  input  logic              c1_we,
  input  logic [W_DATA-1:0] c1_di,
  input  logic              c1_valid,
  output logic [W_DATA-1:0] c1_do,
  output logic              c1_ready,
  output logic [W_ADDR-1:0] m_addr,
  output logic              m_we,
  output logic [W_DATA-1:0] m_di,
  output logic              m_valid,
  input  logic [W_DATA-1:0] m_do,
  input  logic              m_ready
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_LOCKED} state_t;

  state_t             state, state_n;
  logic               g, g_n;
  logic               last_grant, last_grant_n;
  logic               pick;
  logic [W_ADDR-1:0]  m_addr_n;
  logic               m_we_n;
  logic [W_DATA-1:0]  m_di_n;
  logic               m_valid_n;
  logic [W_DATA-1:0]  c0_do_n, c1_do_n;
  logic               c0_ready_n, c1_ready_n;
`ifdef ARRAY_ARB_LOCK_EN
  logic               lock_r, lock_r_n;
`endif

  // Next-state and next-output logic: grant selection, request latch, response capture.
  always_comb begin
    state_n      = state;
    g_n          = g;
    last_grant_n = last_grant;
    pick         = g;
    m_addr_n     = m_addr;
    m_we_n       = m_we;
    m_di_n       = m_di;
    m_valid_n    = m_valid;
    c0_do_n      = c0_do;
    c1_do_n      = c1_do;
    c0_ready_n   = 1'b0;
    c1_ready_n   = 1'b0;
`ifdef ARRAY_ARB_LOCK_EN
    lock_r_n     = lock_r;
`endif
    case (state)
      S_IDLE: begin
        if (c0_valid || c1_valid) begin
          // Tie goes to the client that did not win last time.
          pick      = (c0_valid && c1_valid) ? ~last_grant : c1_valid;
          g_n       = pick;
          m_addr_n  = pick ? c1_addr : c0_addr;
          m_we_n    = pick ? c1_we   : c0_we;
          m_di_n    = pick ? c1_di   : c0_di;
          m_valid_n = 1'b1;
          state_n   = S_REQ;
`ifdef ARRAY_ARB_LOCK_EN
          lock_r_n  = pick ? c1_lock : c0_lock;
`endif
        end
      end
      S_REQ: begin
        if (m_ready) begin
          m_valid_n = 1'b0;
          if (g) begin
            c1_do_n    = m_do;
            c1_ready_n = 1'b1;
          end else begin
            c0_do_n    = m_do;
            c0_ready_n = 1'b1;
          end
          state_n = S_RESP;
        end
      end
      S_RESP: begin
`ifdef ARRAY_ARB_LOCK_EN
        if (lock_r) begin
          state_n = S_LOCKED;
        end else begin
          last_grant_n = g;
          state_n      = S_IDLE;
        end
`else
        last_grant_n = g;
        state_n      = S_IDLE;
`endif
      end
      S_LOCKED: begin
`ifdef ARRAY_ARB_LOCK_EN
        // Only the lock holder is served; the other client waits.
        if (g ? c1_valid : c0_valid) begin
          m_addr_n  = g ? c1_addr : c0_addr;
          m_we_n    = g ? c1_we   : c0_we;
          m_di_n    = g ? c1_di   : c0_di;
          m_valid_n = 1'b1;
          lock_r_n  = g ? c1_lock : c0_lock;
          state_n   = S_REQ;
        end
`else
        state_n = S_IDLE;
`endif
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers; synchronous active-low reset abandons any access.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= S_IDLE;
      g          <= 1'b0;
      last_grant <= 1'b1;
      m_addr     <= '0;
      m_we       <= 1'b0;
      m_di       <= '0;
      m_valid    <= 1'b0;
      c0_do      <= '0;
      c1_do      <= '0;
      c0_ready   <= 1'b0;
      c1_ready   <= 1'b0;
`ifdef ARRAY_ARB_LOCK_EN
      lock_r     <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      g          <= g_n;
      last_grant <= last_grant_n;
      m_addr     <= m_addr_n;
      m_we       <= m_we_n;
      m_di       <= m_di_n;
      m_valid    <= m_valid_n;
      c0_do      <= c0_do_n;
      c1_do      <= c1_do_n;
      c0_ready   <= c0_ready_n;
      c1_ready   <= c1_ready_n;
`ifdef ARRAY_ARB_LOCK_EN
      lock_r     <= lock_r_n;
`endif
    end
  end

endmodule

// File: tb/tb_array_arb2.sv
// tb_array_arb2: scoreboard bench for array_arb2 with a behavioural array memory.
// The bench builds the lock directed test only when ARRAY_ARB_LOCK_EN is defined.
module tb_array_arb2;

  localparam int W_DATA = 8;
  localparam int W_ADDR = 8;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic [W_ADDR-1:0] c0_addr = '0, c1_addr = '0;
  logic              c0_we = 1'b0, c1_we = 1'b0;
  logic [W_DATA-1:0] c0_di = '0, c1_di = '0;
  logic              c0_valid = 1'b0, c1_valid = 1'b0;
  logic [W_DATA-1:0] c0_do, c1_do;
  logic              c0_ready, c1_ready;
  logic [W_ADDR-1:0] m_addr;
  logic              m_we;
  logic [W_DATA-1:0] m_di;
  logic              m_valid;
  logic [W_DATA-1:0] m_do = '0;
  logic              m_ready = 1'b0;
`ifdef ARRAY_ARB_LOCK_EN
  logic              c0_lock = 1'b0, c1_lock = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: per-client expected read data, and expected memory requests in grant order.
  logic [W_DATA-1:0]        exp_q0[$];
  logic [W_DATA-1:0]        exp_q1[$];
  logic [W_ADDR+W_DATA:0]   exp_m_q[$];
  bit                       chk_m = 1'b0;

  // Reference view of array contents, updated when a request is issued.
  logic [W_DATA-1:0] ref_mem [256];
  // Contents held by the behavioural memory model.
  logic [W_DATA-1:0] mem_m   [256];
  int                forced_wait = 0;
  bit                junk_ready_en = 1'b0;

  array_arb2 #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) dut (
    .clk(clk), .nrst(nrst),
`ifdef ARRAY_ARB_LOCK_EN
    .c0_lock(c0_lock), .c1_lock(c1_lock),
`endif
    .c0_addr(c0_addr), .c0_we(c0_we), .c0_di(c0_di), .c0_valid(c0_valid),
    .c0_do(c0_do), .c0_ready(c0_ready),
    .c1_addr(c1_addr), .c1_we(c1_we), .c1_di(c1_di), .c1_valid(c1_valid),
    .c1_do(c1_do), .c1_ready(c1_ready),
    .m_addr(m_addr), .m_we(m_we), .m_di(m_di), .m_valid(m_valid),
    .m_do(m_do), .m_ready(m_ready)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Memory model: a programmable number of wait cycles, then ready with data.
  // Writes return the written data on m_do.
  initial begin
    int  wait_cnt;
    bit  busy;
    busy = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      m_ready = 1'b0;
      if (!nrst) begin
        busy = 1'b0;
      end else if (m_valid) begin
        if (!busy) begin
          busy = 1'b1;
          wait_cnt = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
        end
        if (wait_cnt == 0) begin
          m_ready = 1'b1;
          if (m_we) begin
            mem_m[m_addr] = m_di;
            m_do = m_di;
          end else begin
            m_do = mem_m[m_addr];
          end
          busy = 1'b0;
        end else begin
          wait_cnt--;
        end
      end else if (junk_ready_en && ($urandom_range(0, 3) == 0)) begin
        m_ready = 1'b1;
        m_do = 8'($urandom);
      end
    end
  end

  // Monitor: pops and compares client responses and memory requests.
  initial begin
    bit prev0, prev1, prev_mv;
    prev0 = 1'b0;
    prev1 = 1'b0;
    prev_mv = 1'b0;
    forever begin
      @(negedge clk);
      if (nrst) begin
        if (c0_ready) begin
          check("c0_ready_pulse", {63'b0, prev0}, 64'd0);
          check("c0_vs_c1_ready", {63'b0, c1_ready}, 64'd0);
          if (exp_q0.size() == 0) check("c0_ready_unexpected", {63'b0, c0_ready}, 64'd0);
          else check("c0_do", c0_do, exp_q0.pop_front());
        end
        if (c1_ready) begin
          check("c1_ready_pulse", {63'b0, prev1}, 64'd0);
          if (exp_q1.size() == 0) check("c1_ready_unexpected", {63'b0, c1_ready}, 64'd0);
          else check("c1_do", c1_do, exp_q1.pop_front());
        end
        if (m_valid && !prev_mv && chk_m) begin
          if (exp_m_q.size() == 0) check("m_req_unexpected", {63'b0, m_valid}, 64'd0);
          else check("m_req_order", {m_we, m_addr, m_di}, exp_m_q.pop_front());
        end
      end
      prev0 = c0_ready;
      prev1 = c1_ready;
      prev_mv = m_valid;
    end
  end

  // Driver: issue one client request, wait for its ready, then drop valid.
  task automatic req(input int c, input logic [7:0] a, input bit we, input logic [7:0] di, input bit lk);
    logic [7:0] e;
    int n;
    bit got;
    e = we ? di : ref_mem[a];
    if (we) ref_mem[a] = di;
    if (c == 0) begin
      exp_q0.push_back(e);
      c0_addr = a; c0_we = we; c0_di = di;
`ifdef ARRAY_ARB_LOCK_EN
      c0_lock = lk;
`endif
      c0_valid = 1'b1;
    end else begin
      exp_q1.push_back(e);
      c1_addr = a; c1_we = we; c1_di = di;
`ifdef ARRAY_ARB_LOCK_EN
      c1_lock = lk;
`endif
      c1_valid = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      got = (c == 0) ? c0_ready : c1_ready;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL req_timeout client=%0d actual=no_ready required=ready", c);
    end
    if (c == 0) c0_valid = 1'b0; else c1_valid = 1'b0;
  endtask

  task automatic do_reset();
    c0_valid = 1'b0;
    c1_valid = 1'b0;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {m_valid, m_we, m_addr, m_di, c0_ready, c1_ready, c0_do, c1_do}, 64'd0);
    exp_q0.delete();
    exp_q1.delete();
    exp_m_q.delete();
    nrst = 1'b1;
    @(negedge clk);
  endtask

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      mem_m[i]   = 8'(2 * i + 1);
      ref_mem[i] = 8'(2 * i + 1);
    end
    chk_m = 1'b1;

    // Single read with one wait cycle: arr[3]=7.
    do_reset();
    forced_wait = 1;
    exp_m_q.push_back({1'b0, 8'd3, 8'd0});
    req(0, 8'd3, 1'b0, 8'd0, 1'b0);

    // Tie fairness: two simultaneous pairs, c0 first both times.
    do_reset();
    forced_wait = 0;
    for (int r = 0; r < 2; r++) begin
      exp_m_q.push_back({1'b0, 8'd1, 8'd0});
      exp_m_q.push_back({1'b0, 8'd2, 8'd0});
      fork
        req(0, 8'd1, 1'b0, 8'd0, 1'b0);
        req(1, 8'd2, 1'b0, 8'd0, 1'b0);
      join
      @(negedge clk);
    end

    // Round-robin with c0 continuously requesting: grants 0,1,0,1.
    do_reset();
    exp_m_q.push_back({1'b0, 8'd10, 8'd0});
    exp_m_q.push_back({1'b0, 8'd20, 8'd0});
    exp_m_q.push_back({1'b0, 8'd11, 8'd0});
    exp_m_q.push_back({1'b0, 8'd21, 8'd0});
    fork
      begin req(0, 8'd10, 1'b0, 8'd0, 1'b0); req(0, 8'd11, 1'b0, 8'd0, 1'b0); end
      begin req(1, 8'd20, 1'b0, 8'd0, 1'b0); req(1, 8'd21, 1'b0, 8'd0, 1'b0); end
    join

    // Write then read by c1.
    @(negedge clk);
    forced_wait = 2;
    exp_m_q.push_back({1'b1, 8'd5, 8'd42});
    exp_m_q.push_back({1'b0, 8'd5, 8'd0});
    req(1, 8'd5, 1'b1, 8'd42, 1'b0);
    req(1, 8'd5, 1'b0, 8'd0, 1'b0);

`ifdef ARRAY_ARB_LOCK_EN
    // Lock: c1 must wait until c0's unlocked write completes.
    do_reset();
    forced_wait = 0;
    exp_m_q.push_back({1'b0, 8'd3, 8'd0});
    exp_m_q.push_back({1'b1, 8'd3, 8'd49});
    exp_m_q.push_back({1'b0, 8'd2, 8'd0});
    fork
      begin req(0, 8'd3, 1'b0, 8'd0, 1'b1); req(0, 8'd3, 1'b1, 8'd49, 1'b0); end
      req(1, 8'd2, 1'b0, 8'd0, 1'b0);
    join
`endif

    // Stall, then reset in the middle of the stall.
    do_reset();
    forced_wait = 100000;
    exp_m_q.push_back({1'b0, 8'd9, 8'd0});
    c0_addr = 8'd9; c0_we = 1'b0; c0_di = 8'd0; c0_valid = 1'b1;
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_m_valid_seen", {63'b0, m_valid}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_hold", {m_valid, m_addr, c0_ready, c1_ready}, {1'b1, 8'd9, 1'b0, 1'b0});
    end
    nrst = 1'b0;
    c0_valid = 1'b0;
    @(negedge clk);
    check("midstall_reset_outputs", {m_valid, m_we, m_addr, m_di, c0_ready, c1_ready, c0_do, c1_do}, 64'd0);
    exp_m_q.delete();
    nrst = 1'b1;
    forced_wait = 0;
    @(negedge clk);
    // After the abandoned access the arbiter accepts a fresh request and gives a tie to c0.
    exp_m_q.push_back({1'b0, 8'd4, 8'd0});
    exp_m_q.push_back({1'b0, 8'd6, 8'd0});
    fork
      req(0, 8'd4, 1'b0, 8'd0, 1'b0);
      req(1, 8'd6, 1'b0, 8'd0, 1'b0);
    join

    // Randomised traffic on disjoint address halves, random waits, stray m_ready.
    @(negedge clk);
    chk_m = 1'b0;
    forced_wait = -1;
    junk_ready_en = 1'b1;
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        req(0, 8'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
      end
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        req(1, 8'($urandom_range(128, 255)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
      end
    join
    junk_ready_en = 1'b0;
    repeat (5) @(negedge clk);

    check("q0_drained", exp_q0.size(), 64'd0);
    check("q1_drained", exp_q1.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
